// File: rtl/shared_reg_pkg.sv
// -----------------------------------------------------------------------------
// shared_reg_pkg
// Shared definitions for the shared-register arbiter:
//   - state_t        : two-state write FSM encoding (IDLE, WRITE)
//   - N_REQ_DEF      : default number of requesters
//   - WIDTH_DEF      : default shared-register width
//   - WCOUNT_W       : width of the optional completed-write counter
// -----------------------------------------------------------------------------
package shared_reg_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    localparam int N_REQ_DEF = 4;
    localparam int WIDTH_DEF = 8;
    localparam int WCOUNT_W  = 16;

endpackage : shared_reg_pkg

// File: rtl/shared_reg_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin selector. Scans req starting at position ptr and
// wrapping modulo N_REQ; reports the first set bit.
// Ports:
//   req   [N_REQ-1:0] in  : request vector
//   ptr   [PW-1:0]    in  : highest-priority position (0..N_REQ-1)
//   valid             out : at least one request is set
//   index [PW-1:0]    out : selected requester (0 when valid is low)
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int PW    = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic             valid,
    output logic [PW-1:0]    index
);

    // Priority scan: walk from lowest to highest priority so the last hit
    // (the one closest to ptr) overwrites earlier ones.
    always_comb begin
        logic [PW:0] pos;
        valid = 1'b0;
        index = '0;
        pos   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            // ptr + k never exceeds 2*N_REQ-2, so one conditional subtract wraps it
            pos = {1'b0, ptr} + (PW + 1)'(k);
            if (pos >= (PW + 1)'(N_REQ)) begin
                pos = pos - (PW + 1)'(N_REQ);
            end else begin
                pos = pos;
            end
            if (req[pos[PW-1:0]]) begin
                valid = 1'b1;
                index = pos[PW-1:0];
            end else begin
                valid = valid;
                index = index;
            end
        end
    end

endmodule : rr_pick

// File: rtl/shared_reg_arbiter.sv
// -----------------------------------------------------------------------------
// shared_reg_arbiter
// Round-robin arbitration of N_REQ writers onto one shared register.
// IDLE picks and latches a winner; WRITE commits the winner's data if its
// request is still held (gnt pulses in the cycle after that commit edge),
// otherwise the write is aborted with no side effects.
// Optional feature macro: SHARED_REG_WCOUNT_EN adds a saturating count of
// completed writes on port wcount.
// Ports:
//   clk        in  : clock, rising edge
//   rst_async  in  : asynchronous active-high reset
//   rst_sync   in  : synchronous active-high clear, overrides all activity
//   req        in  : per-requester level write request
//   wdata      in  : requester i data at [i*WIDTH +: WIDTH]
//   gnt        out : one-hot registered grant pulse
//   q          out : shared register contents
//   busy       out : FSM is in WRITE
//   wcount     out : completed-write count (only with SHARED_REG_WCOUNT_EN)
// -----------------------------------------------------------------------------
module shared_reg_arbiter
    import shared_reg_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst_async,
    input  logic                   rst_sync,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] wdata,
    output logic [N_REQ-1:0]       gnt,
    output logic [WIDTH-1:0]       q,
    output logic                   busy
`ifdef SHARED_REG_WCOUNT_EN
    ,
    output logic [WCOUNT_W-1:0]    wcount
`endif
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_t            state_q, state_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [PW-1:0]     winner_q, winner_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic [WIDTH-1:0]  q_q, q_d;
    logic              busy_q;
    logic              pick_valid_s;
    logic [PW-1:0]     pick_idx_s;
    logic [WIDTH-1:0]  wdata_arr_s [N_REQ];

    rr_pick #(
        .N_REQ (N_REQ),
        .PW    (PW)
    ) u_rr_pick (
        .req   (req),
        .ptr   (ptr_q),
        .valid (pick_valid_s),
        .index (pick_idx_s)
    );

    // Unpack the flat write-data bus into per-requester lanes.
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            wdata_arr_s[i] = wdata[i*WIDTH +: WIDTH];
        end
    end

    // Next-state and output decode for the IDLE/WRITE FSM.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        winner_d = winner_q;
        gnt_d    = '0;
        q_d      = q_q;
        if (rst_sync) begin
            // Clear wins over everything, including a pending WRITE.
            state_d  = IDLE;
            ptr_d    = '0;
            winner_d = '0;
            q_d      = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_valid_s) begin
                        winner_d = pick_idx_s;
                        state_d  = WRITE;
                    end else begin
                        state_d  = IDLE;
                    end
                end
                WRITE: begin
                    state_d = IDLE;
                    if (req[winner_q]) begin
                        gnt_d[winner_q] = 1'b1;
                        q_d             = wdata_arr_s[winner_q];
                        if (winner_q == PW'(N_REQ - 1)) begin
                            ptr_d = '0;
                        end else begin
                            ptr_d = winner_q + 1'b1;
                        end
                    end else begin
                        // Requester withdrew: abort without touching q or ptr.
                        ptr_d = ptr_q;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State, pointer, grant and data registers.
    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            winner_q <= '0;
            gnt_q    <= '0;
            q_q      <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            winner_q <= winner_d;
            gnt_q    <= gnt_d;
            q_q      <= q_d;
            busy_q   <= (state_d == WRITE);
        end
    end

    assign gnt  = gnt_q;
    assign q    = q_q;
    assign busy = busy_q;

`ifdef SHARED_REG_WCOUNT_EN
    logic                write_done_s;
    logic [WCOUNT_W-1:0] wcount_q, wcount_d;

    assign write_done_s = !rst_sync && (state_q == WRITE) && req[winner_q];

    // Saturating count of completed writes.
    always_comb begin
        wcount_d = wcount_q;
        if (rst_sync) begin
            wcount_d = '0;
        end else if (write_done_s && (wcount_q != {WCOUNT_W{1'b1}})) begin
            wcount_d = wcount_q + 1'b1;
        end else begin
            wcount_d = wcount_q;
        end
    end

    // Completed-write counter register.
    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            wcount_q <= '0;
        end else begin
            wcount_q <= wcount_d;
        end
    end

    assign wcount = wcount_q;
`endif

endmodule : shared_reg_arbiter
